// File: rtl/sdram_host_tester.sv
// SDRAM controller self-test. It writes a pattern over 0..ADDR_LAST, reads the sweep back and compares each word, and slots refreshes in between operations.
// Optional macro SDRAM_TESTER_INVERT_PASS_EN adds a second write/read sweep that uses the inverted pattern.
module sdram_host_tester #(
    parameter logic [21:0] ADDR_LAST   = 22'h3FFFFF,
    parameter logic [15:0] SEED        = 16'hA5C3,
    parameter int          RFSH_CYCLES = 1000,
    parameter int          TIMEOUT     = 255
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    output logic [21:0] sys_addr,
    output logic        sys_write_rq,
    output logic        sys_read_rq,
    output logic        sys_rfsh_rq,
    output logic [15:0] sys_data_in,
    input  logic [15:0] sys_data_out,
    input  logic        sys_busy,
    output logic        running,
    output logic        done,
    output logic        pass,
    output logic [21:0] err_addr,
    output logic [15:0] err_data,
    output logic [15:0] err_exp,
    output logic        timeout_err,
    output logic [3:0]  dbg_state_o
);

    localparam int RF_W  = (RFSH_CYCLES > 1) ? $clog2(RFSH_CYCLES) : 1;
    localparam int TMO_W = $clog2(TIMEOUT + 1);

    typedef enum logic [3:0] {
        S_IDLE, S_WR_REQ, S_WR_WAIT, S_RD_REQ, S_RD_WAIT,
        S_CHECK, S_RF_REQ, S_RF_WAIT, S_DONE
    } state_t;

    state_t       state_q, state_d;
    logic [21:0]  addr_q, addr_d;
    logic         phase_q, phase_d;      // 0: write sweep, 1: read sweep
    logic         inv_q, inv_d;          // inverted-pattern pass
    logic [15:0]  rdata_q, rdata_d;
    logic         running_q, running_d, done_q, done_d, pass_q, pass_d;
    logic         tmo_err_q, tmo_err_d;
    logic [21:0]  err_addr_q, err_addr_d;
    logic [15:0]  err_data_q, err_data_d, err_exp_q, err_exp_d;
    logic [TMO_W-1:0] tmo_q;
    logic [RF_W-1:0]  rf_cnt_q;
    logic         rf_pend_q;
    logic         start_acc, rf_clr, tmo_hit, last, wait_st;
    logic [15:0]  pat_raw, pat;

    assign pat_raw = addr_q[15:0] ^ {10'b0, addr_q[21:16]} ^ SEED;
    assign pat     = inv_q ? ~pat_raw : pat_raw;
    assign last    = (addr_q == ADDR_LAST);
    assign tmo_hit = (tmo_q == TMO_W'(TIMEOUT - 1));
    assign wait_st = state_q inside {S_WR_REQ, S_WR_WAIT, S_RD_REQ, S_RD_WAIT, S_RF_REQ, S_RF_WAIT};

    // Handshake: a request strobe stays high from *_REQ entry until sys_busy=1 is sampled,
    // drops the next cycle (*_WAIT), and the op completes in the first cycle sys_busy=0 is seen.
    assign sys_write_rq = (state_q == S_WR_REQ);
    assign sys_read_rq  = (state_q == S_RD_REQ);
    assign sys_rfsh_rq  = (state_q == S_RF_REQ);
    assign sys_addr     = addr_q;
    assign sys_data_in  = (state_q inside {S_WR_REQ, S_WR_WAIT}) ? pat : 16'h0000;
    assign running      = running_q;
    assign done         = done_q;
    assign pass         = pass_q;
    assign timeout_err  = tmo_err_q;
    assign err_addr     = err_addr_q;
    assign err_data     = err_data_q;
    assign err_exp      = err_exp_q;
    assign dbg_state_o  = state_q;

    always_comb begin
        state_d    = state_q;
        addr_d     = addr_q;
        phase_d    = phase_q;
        inv_d      = inv_q;
        rdata_d    = rdata_q;
        running_d  = running_q;
        done_d     = done_q;
        pass_d     = pass_q;
        tmo_err_d  = tmo_err_q;
        err_addr_d = err_addr_q;
        err_data_d = err_data_q;
        err_exp_d  = err_exp_q;
        start_acc  = 1'b0;
        rf_clr     = 1'b0;
        case (state_q)
            S_IDLE: if (start) begin
                start_acc  = 1'b1;
                state_d    = S_WR_REQ;
                addr_d     = '0;
                phase_d    = 1'b0;
                inv_d      = 1'b0;
                running_d  = 1'b1;
                done_d     = 1'b0;
                pass_d     = 1'b0;
                tmo_err_d  = 1'b0;
                err_addr_d = '0;
                err_data_d = '0;
                err_exp_d  = '0;
            end
            S_WR_REQ: if (sys_busy) state_d = S_WR_WAIT;
            S_WR_WAIT: if (!sys_busy) begin
                if (last) begin
                    addr_d  = '0;
                    phase_d = 1'b1;
                end else begin
                    addr_d = addr_q + 22'd1;
                end
                state_d = rf_pend_q ? S_RF_REQ : (last ? S_RD_REQ : S_WR_REQ);
            end
            S_RD_REQ: if (sys_busy) state_d = S_RD_WAIT;
            S_RD_WAIT: if (!sys_busy) begin
                rdata_d = sys_data_out;
                state_d = S_CHECK;
            end
            S_CHECK: begin
                if (rdata_q != pat) begin
                    err_addr_d = addr_q;
                    err_data_d = rdata_q;
                    err_exp_d  = pat;
                    pass_d     = 1'b0;
                    state_d    = S_DONE;
                end else if (last) begin
`ifdef SDRAM_TESTER_INVERT_PASS_EN
                    if (!inv_q) begin
                        inv_d   = 1'b1;
                        phase_d = 1'b0;
                        addr_d  = '0;
                        state_d = rf_pend_q ? S_RF_REQ : S_WR_REQ;
                    end else begin
                        pass_d  = 1'b1;
                        state_d = S_DONE;
                    end
`else
                    pass_d  = 1'b1;
                    state_d = S_DONE;
`endif
                end else begin
                    addr_d  = addr_q + 22'd1;
                    state_d = rf_pend_q ? S_RF_REQ : S_RD_REQ;
                end
            end
            S_RF_REQ: if (sys_busy) begin
                rf_clr  = 1'b1;
                state_d = S_RF_WAIT;
            end
            S_RF_WAIT: if (!sys_busy) state_d = phase_q ? S_RD_REQ : S_WR_REQ;
            S_DONE: state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
        if (wait_st && state_d == state_q && tmo_hit) begin
            tmo_err_d = 1'b1;
            pass_d    = 1'b0;
            state_d   = S_DONE;
        end
        if (state_d == S_DONE && state_q != S_DONE) begin
            running_d = 1'b0;
            done_d    = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= S_IDLE;
            addr_q     <= '0;
            phase_q    <= 1'b0;
            inv_q      <= 1'b0;
            rdata_q    <= '0;
            running_q  <= 1'b0;
            done_q     <= 1'b0;
            pass_q     <= 1'b0;
            tmo_err_q  <= 1'b0;
            err_addr_q <= '0;
            err_data_q <= '0;
            err_exp_q  <= '0;
        end else begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            phase_q    <= phase_d;
            inv_q      <= inv_d;
            rdata_q    <= rdata_d;
            running_q  <= running_d;
            done_q     <= done_d;
            pass_q     <= pass_d;
            tmo_err_q  <= tmo_err_d;
            err_addr_q <= err_addr_d;
            err_data_q <= err_data_d;
            err_exp_q  <= err_exp_d;
        end
    end

    // Timeout counter restarts whenever the state changes.
    always_ff @(posedge clk) begin
        if (reset || state_d != state_q) tmo_q <= '0;
        else                             tmo_q <= tmo_q + 1'b1;
    end

    // A set in the same cycle as a clear wins, so a fresh expiry is never lost.
    always_ff @(posedge clk) begin
        if (reset || start_acc) begin
            rf_cnt_q  <= RF_W'(RFSH_CYCLES - 1);
            rf_pend_q <= 1'b0;
        end else begin
            if (rf_clr) rf_pend_q <= 1'b0;
            if (running_q) begin
                if (rf_cnt_q == '0) begin
                    rf_cnt_q  <= RF_W'(RFSH_CYCLES - 1);
                    rf_pend_q <= 1'b1;
                end else begin
                    rf_cnt_q <= rf_cnt_q - 1'b1;
                end
            end
        end
    end

endmodule

// File: doc/sdram_host_tester.md
SDRAM_HOST_TESTER -- requirements
Module: sdram_host_tester

Interface
REQ-001 Parameter ADDR_LAST, 22'h3FFFFF, last word address tested; the sweep covers 0..ADDR_LAST.
REQ-002 Parameter SEED, 16'hA5C3, pattern seed.
REQ-003 Parameter RFSH_CYCLES, 1000, clk cycles between refresh requests.
REQ-004 Parameter TIMEOUT, 255, max clk cycles to wait for each sys_busy edge.
REQ-005 clk  in  1  system clock, same clock as the controller's sys_clk.
REQ-006 reset  in  1  reset, synchronous, active-high.
REQ-007 start  in  1  one-cycle pulse that begins a test; ignored while running=1.
REQ-008 sys_addr  out  22  word address to the controller.
REQ-009 sys_write_rq / sys_read_rq / sys_rfsh_rq  out  1 each  request strobes; at most one high at a time.
REQ-010 sys_data_in  out  16  write data to the controller.
REQ-011 sys_data_out  in  16  read data from the controller.
REQ-012 sys_busy  in  1  controller busy flag.
REQ-013 running / done / pass  out  1 each  test status.
REQ-014 err_addr  out  22 and err_data, err_exp  out  16  address, read data and expected data of the first mismatch.
REQ-015 timeout_err  out  1  set when a busy edge is not seen within TIMEOUT cycles.

Function
REQ-016 Pattern: pat(a) = a[15:0] ^ {10'b0, a[21:16]} ^ SEED, computed combinationally from the current address.
REQ-017 States: IDLE, WR_REQ, WR_WAIT, RD_REQ, RD_WAIT, CHECK, RF_REQ, RF_WAIT, DONE.
REQ-018 IDLE to WR_REQ on start. On that edge: addr=0, running=1, done=0, pass=0, timeout_err=0.
REQ-019 Request handshake:
- Assert the request and hold it until sys_busy=1 is sampled.
- Deassert the request in the following cycle.
- In the *_WAIT state, wait for sys_busy=0; that cycle completes the operation.
REQ-020 Write phase: each op drives sys_addr=addr and sys_data_in=pat(addr). The stable address and data are held from request through completion. When addr==ADDR_LAST, the next op is a read at address 0; otherwise addr increments.
REQ-021 Read phase: sys_data_out is captured in the completion cycle (busy seen low). CHECK compares the captured data with pat(addr) one cycle later.
REQ-022 On mismatch: latch err_addr, err_data and err_exp, then go to DONE with pass=0 (stop on first error).
REQ-023 On a match at ADDR_LAST: go to DONE with pass=1. Otherwise increment addr and go to RD_REQ.
REQ-024 DONE: done=1 and running=0. Return to IDLE next cycle; done, pass and err_* hold until the next start.
REQ-025 Refresh counter:
- Free-running down-counter, reloaded with RFSH_CYCLES-1.
- Sets rfsh_pending=1 on reaching 0.
- rfsh_pending is cleared when the RF_REQ handshake sees sys_busy=1.
- A second expiry while pending does not queue a second refresh.
REQ-026 Refresh priority: when rfsh_pending=1 at an operation boundary (completion of any op, or before the first op), the next state is RF_REQ. RF_WAIT then resumes the interrupted sequence at the same addr. A refresh never interrupts an op in flight.
REQ-027 The refresh counter runs only while running=1. It is reloaded when start is accepted.
REQ-028 Timeout: a cycle counter restarts on every *_REQ and *_WAIT entry. On reaching TIMEOUT: timeout_err=1, pass=0, go to DONE.
REQ-029 Simultaneous start and done in the same cycle: start is ignored.

Reset
REQ-030 Reset forces the following, overriding all other activity including a mid-operation request:
- State IDLE.
- All request outputs 0; sys_addr=0, sys_data_in=0.
- running, done, pass, timeout_err all 0.
- err_* = 0.
- rfsh_pending=0 and the refresh counter reloaded.

Configuration
REQ-031 Macro SDRAM_TESTER_INVERT_PASS_EN.
- Defined: after the first read phase passes, a second write phase and a second read phase run with pattern ~pat(a). pass=1 only after both read phases succeed.
- Undefined: a single write and read sweep only.

Verification
REQ-032 ADDR_LAST=15, ideal controller model (busy high 4 cycles per op), start -> 16 writes of pat(0..15), 16 reads, done=1, pass=1.
REQ-033 Same setup, model corrupts word 7 on read (returns 16'h0000) -> done=1, pass=0, err_addr=7, err_exp=pat(7), err_data=16'h0000, no reads after address 7.
REQ-034 RFSH_CYCLES=10, ADDR_LAST=63 -> sys_rfsh_rq asserted only between ops, each time after expiry; sweep completes with pass=1 and every address written and read exactly once.
REQ-035 Model never raises busy, TIMEOUT=255 -> timeout_err=1 exactly 255 cycles after sys_write_rq rises, then done=1, pass=0.
REQ-036 Reset asserted during RD_WAIT -> next cycle in IDLE, all request outputs 0, running=0; a subsequent start restarts at addr 0.
REQ-037 With SDRAM_TESTER_INVERT_PASS_EN defined and ADDR_LAST=3 -> second write sweep writes ~pat(0..3), 8 total reads, pass=1.
